// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions used by the control unit and the
// execute/memory stage.
//   - ALU operation encodings carried in the buffered control word
//   - opcode constants the control unit decodes into control words
//   - execute/memory stage state enum
package pipeline_pkg;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_NOT = 2'd1;
  localparam logic [1:0] ALU_NOP = 2'd2;

  localparam logic [3:0] OPC_ADD   = 4'h0;
  localparam logic [3:0] OPC_NOT   = 4'h1;
  localparam logic [3:0] OPC_NOP   = 4'h2;
  localparam logic [3:0] OPC_LOAD  = 4'h3;
  localparam logic [3:0] OPC_STORE = 4'h4;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } exm_state_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU for the execute/memory stage.
// Ports:
//   alu_operation  in  2       operation select (add / not / nop; reserved acts as nop)
//   src_a, src_b   in  DATA_W  operands
//   result         out DATA_W  operation result, carry dropped on add
module alu
  import pipeline_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [1:0]        alu_operation,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  output logic [DATA_W-1:0] result
);

  always_comb begin
    result = '0;
    case (alu_operation)
      ALU_ADD: result = src_a + src_b;
      ALU_NOT: result = ~src_a;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/ex_mem_stage.sv
// Execute/memory stage. Runs ALU operations in one cycle or a single
// data-memory access over a req/ack handshake, and emits one registered
// writeback record per retired instruction.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   in_valid / in_ready        upstream handshake; in_ready low while in MEM_WAIT
//   mem_read, mem_write        load / store flags (both set = illegal word)
//   alu_operation, wb, rd_addr control word fields
//   src_a, src_b               register operands
//   dmem_req/we/addr/wdata     data-memory request, held until ack or timeout
//   dmem_rdata, dmem_ack       memory response
//   wb_valid/en/addr/data      writeback record, one-cycle valid pulse
//   err                        one-cycle pulse on timeout or illegal word
//
// state    | meaning
// ---------+---------------------------------------------------------
// RUN      | accepting; ALU ops retire next cycle
// MEM_WAIT | memory request outstanding; waiting for ack or timeout
module ex_mem_stage
  import pipeline_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 10,
  parameter int REG_W   = 3,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        alu_operation,
  input  logic              wb,
  input  logic [REG_W-1:0]  rd_addr,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              wb_valid,
  output logic              wb_en,
  output logic [REG_W-1:0]  wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  exm_state_t        state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [REG_W-1:0]  lat_rd, lat_rd_n;
  logic              req_n, we_n;
  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] wdata_n;
  logic              wb_valid_n, wb_en_n, err_n;
  logic [REG_W-1:0]  wb_addr_n;
  logic [DATA_W-1:0] wb_data_n;
  logic [DATA_W-1:0] alu_result;

  alu #(.DATA_W(DATA_W)) u_alu (
    .alu_operation (alu_operation),
    .src_a         (src_a),
    .src_b         (src_b),
    .result        (alu_result)
  );

  assign in_ready = (state == RUN);

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    lat_rd_n   = lat_rd;
    req_n      = dmem_req;
    we_n       = dmem_we;
    addr_n     = dmem_addr;
    wdata_n    = dmem_wdata;
    wb_valid_n = 1'b0;
    wb_en_n    = 1'b0;
    wb_addr_n  = wb_addr;
    wb_data_n  = wb_data;
    err_n      = 1'b0;

    case (state)
      RUN: begin
        if (in_valid) begin
          if (mem_read && mem_write) begin
            wb_valid_n = 1'b1;
            wb_addr_n  = rd_addr;
            wb_data_n  = '0;
            err_n      = 1'b1;
          end else if (mem_read || mem_write) begin
            state_n  = MEM_WAIT;
            cnt_n    = '0;
            lat_rd_n = rd_addr;
            req_n    = 1'b1;
            we_n     = mem_write;
            addr_n   = src_a[ADDR_W-1:0];
            wdata_n  = src_b;
          end else begin
            wb_valid_n = 1'b1;
            wb_en_n    = wb;
            wb_addr_n  = rd_addr;
            wb_data_n  = alu_result;
          end
        end
      end
      MEM_WAIT: begin
        // Ack is checked first so a coincident ack beats the timeout.
        if (dmem_ack) begin
          state_n    = RUN;
          req_n      = 1'b0;
          wb_valid_n = 1'b1;
          wb_en_n    = !dmem_we;
          wb_addr_n  = lat_rd;
          wb_data_n  = dmem_we ? '0 : dmem_rdata;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          // TIMEOUT-1 here means the request has now been up TIMEOUT cycles.
          state_n    = RUN;
          req_n      = 1'b0;
          wb_valid_n = 1'b1;
          wb_addr_n  = lat_rd;
          wb_data_n  = '0;
          err_n      = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      cnt        <= '0;
      lat_rd     <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      wb_valid   <= 1'b0;
      wb_en      <= 1'b0;
      wb_addr    <= '0;
      wb_data    <= '0;
      err        <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      lat_rd     <= lat_rd_n;
      dmem_req   <= req_n;
      dmem_we    <= we_n;
      dmem_addr  <= addr_n;
      dmem_wdata <= wdata_n;
      wb_valid   <= wb_valid_n;
      wb_en      <= wb_en_n;
      wb_addr    <= wb_addr_n;
      wb_data    <= wb_data_n;
      err        <= err_n;
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
module tb_ex_mem_stage;

  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 10;
  localparam int REG_W   = 3;
  localparam int TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic              mem_read, mem_write;
  logic [1:0]        alu_operation;
  logic              wb;
  logic [REG_W-1:0]  rd_addr;
  logic [DATA_W-1:0] src_a, src_b;
  logic              dmem_req, dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata, dmem_rdata;
  logic              dmem_ack;
  logic              wb_valid, wb_en;
  logic [REG_W-1:0]  wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              err;

  typedef struct packed {
    logic              en;
    logic [REG_W-1:0]  addr;
    logic [DATA_W-1:0] data;
    logic              err;
  } wb_rec_t;

  wb_rec_t exp_q[$];
  int tests = 0;
  int fails = 0;

  ex_mem_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_W(REG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .alu_operation (alu_operation),
    .wb            (wb),
    .rd_addr       (rd_addr),
    .src_a         (src_a),
    .src_b         (src_b),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_rdata    (dmem_rdata),
    .dmem_ack      (dmem_ack),
    .wb_valid      (wb_valid),
    .wb_en         (wb_en),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .err           (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] model_alu(input logic [1:0] op,
                                                  input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
    case (op)
      2'd0:    return a + b;
      2'd1:    return ~a;
      default: return '0;
    endcase
  endfunction

  // Scoreboard: every retire pulse must match the oldest expected record.
  always @(negedge clk) begin
    if (wb_valid) begin
      if (exp_q.size() == 0) begin
        chk("wb_unexpected", 32'(wb_valid), 32'd0);
      end else begin
        wb_rec_t e;
        e = exp_q.pop_front();
        chk("wb_en",   32'(wb_en),   32'(e.en));
        chk("wb_addr", 32'(wb_addr), 32'(e.addr));
        chk("wb_data", 32'(wb_data), 32'(e.data));
        chk("wb_err",  32'(err),     32'(e.err));
      end
    end else begin
      chk("err_idle", 32'(err), 32'd0);
    end
  end

  task automatic drive(input logic rd_f, input logic wr_f, input logic [1:0] op,
                       input logic w, input logic [REG_W-1:0] rd,
                       input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    in_valid = 1'b1; mem_read = rd_f; mem_write = wr_f;
    alu_operation = op; wb = w; rd_addr = rd; src_a = a; src_b = b;
  endtask

  task automatic push(input logic en, input logic [REG_W-1:0] a,
                      input logic [DATA_W-1:0] d, input logic e);
    wb_rec_t r;
    r.en = en; r.addr = a; r.data = d; r.err = e;
    exp_q.push_back(r);
  endtask

  task automatic alu_step(input logic [1:0] op, input logic w, input logic [REG_W-1:0] rd,
                          input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    drive(1'b0, 1'b0, op, w, rd, a, b);
    push(w, rd, model_alu(op, a, b), 1'b0);
    chk("in_ready_alu", 32'(in_ready), 32'd1);
    @(negedge clk);
  endtask

  // Called at the negedge just after the accept edge. Checks req is held with
  // stable fields; raises ack during cycle ack_cycle (0 = never).
  task automatic mem_phase(input int ack_cycle, input logic [DATA_W-1:0] rdata,
                           input logic exp_we, input logic [ADDR_W-1:0] exp_addr,
                           input logic [DATA_W-1:0] exp_wdata);
    for (int i = 1; i <= TIMEOUT; i++) begin
      chk("req_held",   32'(dmem_req),   32'd1);
      chk("in_ready_w", 32'(in_ready),   32'd0);
      chk("dmem_we",    32'(dmem_we),    32'(exp_we));
      chk("dmem_addr",  32'(dmem_addr),  32'(exp_addr));
      chk("dmem_wdata", 32'(dmem_wdata), 32'(exp_wdata));
      if (i == ack_cycle) begin
        dmem_ack = 1'b1; dmem_rdata = rdata;
      end
      @(negedge clk);
      dmem_ack = 1'b0; dmem_rdata = '0;
      if (i == ack_cycle) break;
    end
    chk("req_dropped", 32'(dmem_req), 32'd0);
    chk("in_ready_back", 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    alu_operation = 2'd2; wb = 1'b0; rd_addr = '0; src_a = '0; src_b = '0;
    dmem_rdata = '0; dmem_ack = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_req",      32'(dmem_req), 32'd0);
    chk("rst_we",       32'(dmem_we), 32'd0);
    chk("rst_addr",     32'(dmem_addr), 32'd0);
    chk("rst_wdata",    32'(dmem_wdata), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_out",   32'({wb_en, wb_addr, wb_data}), 32'd0);
    rst = 1'b0;

    // ALU: add, add with wrap, back-to-back not then nop, reserved op
    alu_step(2'd0, 1'b1, 3'd2, 16'h0005, 16'h0003);
    alu_step(2'd0, 1'b1, 3'd3, 16'hFFFF, 16'h0001);
    alu_step(2'd1, 1'b1, 3'd4, 16'h00F0, 16'h0000);
    alu_step(2'd2, 1'b0, 3'd5, 16'h1111, 16'h2222);
    alu_step(2'd3, 1'b1, 3'd1, 16'h1234, 16'h4321);
    in_valid = 1'b0;
    @(negedge clk);

    // Load, ack on the third request cycle
    drive(1'b1, 1'b0, 2'd2, 1'b1, 3'd6, 16'h0040, 16'h5555);
    push(1'b1, 3'd6, 16'hBEEF, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    mem_phase(3, 16'hBEEF, 1'b0, 10'h040, 16'h5555);

    // Store with the following add held valid upstream throughout
    drive(1'b0, 1'b1, 2'd2, 1'b1, 3'd1, 16'h0123, 16'h1234);
    push(1'b0, 3'd1, 16'h0000, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 2'd0, 1'b1, 3'd3, 16'h0100, 16'h0023);
    push(1'b1, 3'd3, 16'h0123, 1'b0);
    mem_phase(2, 16'hDEAD, 1'b1, 10'h123, 16'h1234);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);

    // Timeout with no ack
    drive(1'b1, 1'b0, 2'd2, 1'b1, 3'd7, 16'hF3FF, 16'h0000);
    push(1'b0, 3'd7, 16'h0000, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    mem_phase(0, 16'h0000, 1'b0, 10'h3FF, 16'h0000);
    @(negedge clk);

    // Ack on the final allowed cycle beats the timeout
    drive(1'b1, 1'b0, 2'd2, 1'b1, 3'd7, 16'h0200, 16'h0000);
    push(1'b1, 3'd7, 16'hCAFE, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    mem_phase(TIMEOUT, 16'hCAFE, 1'b0, 10'h200, 16'h0000);
    @(negedge clk);

    // Illegal control word
    drive(1'b1, 1'b1, 2'd0, 1'b1, 3'd5, 16'h0010, 16'h0020);
    push(1'b0, 3'd5, 16'h0000, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("illegal_no_req", 32'(dmem_req), 32'd0);
    chk("illegal_ready",  32'(in_ready), 32'd1);
    @(negedge clk);

    // Reset in the middle of MEM_WAIT abandons the access
    drive(1'b1, 1'b0, 2'd2, 1'b1, 3'd2, 16'h0077, 16'h0000);
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre_rst_req", 32'(dmem_req), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_req",   32'(dmem_req), 32'd0);
    chk("rst_mid_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);

    // Reset has priority over a same-cycle accept
    drive(1'b0, 1'b0, 2'd0, 1'b1, 3'd4, 16'h0001, 16'h0001);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    chk("rst_prio_valid", 32'(wb_valid), 32'd0);
    repeat (3) @(negedge clk);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
